fifo_wr_ptr_ctrl: RTL

FIFO_WR_PTR_CTRL -- requirements
Module: fifo_wr_ptr_ctrl

---
 rtl/fifo_wr_ptr_ctrl_if.sv | 46 ++++
 rtl/fifo_wr_ptr_ctrl.sv | 111 +++++++++++
 2 files changed

// File: rtl/fifo_wr_ptr_ctrl_if.sv
// rtl/fifo_wr_ptr_ctrl_if.sv - producer-side bundle of the FIFO write-pointer controller
//
// Signals:
//   write       producer write request
//   ovf_clear   clears the sticky overflow flag
//   wr_en       memory write enable (write accepted this cycle)
//   wr_addr     binary memory write address
//   full        registered FIFO-full flag
//   almost_full registered fill level >= threshold
//   wr_level    registered fill level, 0..2^ADDR_WIDTH
//   overflow    sticky flag: write attempted while full
// Modports: master = producer side, slave = controller side.
interface fifo_wr_ptr_ctrl_if #(
    parameter int ADDR_WIDTH = 4
);
    logic                  write;
    logic                  ovf_clear;
    logic                  wr_en;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic                  full;
    logic                  almost_full;
    logic [ADDR_WIDTH:0]   wr_level;
    logic                  overflow;

    modport master (
        output write,
        output ovf_clear,
        input  wr_en,
        input  wr_addr,
        input  full,
        input  almost_full,
        input  wr_level,
        input  overflow
    );

    modport slave (
        input  write,
        input  ovf_clear,
        output wr_en,
        output wr_addr,
        output full,
        output almost_full,
        output wr_level,
        output overflow
    );
endinterface

// File: rtl/fifo_wr_ptr_ctrl.sv
// rtl/fifo_wr_ptr_ctrl.sv - write-side pointer, full/level flags of an async FIFO
//
// Ports:
//   clk          write-domain clock, rising edge
//   reset_n      synchronous active-low reset
//   rd_ptr_gray  read pointer (Gray) from the read domain, asynchronous to clk
//   wr_ptr       registered Gray write pointer sent to the read domain
//   bus          producer bundle (write, ovf_clear, wr_en, wr_addr, full,
//                almost_full, wr_level, overflow)
// Build option:
//   FIFO_WR_OVERFLOW_FLAG_EN  compiles in the sticky overflow flag; otherwise
//                             overflow is tied to 0 and ovf_clear is ignored.
module fifo_wr_ptr_ctrl #(
    parameter int ADDR_WIDTH         = 4,
    parameter int ALMOST_FULL_THRESH = 12
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [ADDR_WIDTH:0] rd_ptr_gray,
    output logic [ADDR_WIDTH:0] wr_ptr,
    fifo_wr_ptr_ctrl_if.slave   bus
);
    localparam logic [ADDR_WIDTH:0] AF_THRESH = (ADDR_WIDTH+1)'(ALMOST_FULL_THRESH);

    logic [ADDR_WIDTH:0] bin_q, bin_d;
    logic [ADDR_WIDTH:0] gptr_q, gptr_d;
    logic [ADDR_WIDTH:0] rq1_q, rq1_d;
    logic [ADDR_WIDTH:0] rq2_q, rq2_d;
    logic [ADDR_WIDTH:0] level_q, level_d;
    logic                full_q, full_d;
    logic                af_q, af_d;
    logic                ovf_q, ovf_d;
    logic                in_reset_q, in_reset_d;

    logic                accept;
    logic [ADDR_WIDTH:0] bnext;
    logic [ADDR_WIDTH:0] gnext;
    logic [ADDR_WIDTH:0] rbin;
    logic [ADDR_WIDTH:0] level_next;
    logic [ADDR_WIDTH:0] full_cmp;

    always_comb begin
        // in_reset_q holds writes off until the first edge after reset release
        accept     = bus.write & ~full_q & ~in_reset_q;
        bnext      = bin_q + {{ADDR_WIDTH{1'b0}}, accept};
        gnext      = (bnext >> 1) ^ bnext;

        // Gray to binary: each binary bit is the XOR of all Gray bits at or above it
        rbin = '0;
        for (int i = 0; i <= ADDR_WIDTH; i++) begin
            rbin[i] = ^(rq2_q >> i);
        end

        level_next = bnext - rbin;
        // Full when the write pointer has lapped the read pointer exactly once:
        // top two Gray bits inverted, remainder equal.
        full_cmp   = {~rq2_q[ADDR_WIDTH:ADDR_WIDTH-1], rq2_q[ADDR_WIDTH-2:0]};

        bin_d      = bnext;
        gptr_d     = gnext;
        rq1_d      = rd_ptr_gray;
        rq2_d      = rq1_q;
        level_d    = level_next;
        full_d     = (gnext == full_cmp);
        af_d       = (level_next >= AF_THRESH);
        in_reset_d = 1'b0;
`ifdef FIFO_WR_OVERFLOW_FLAG_EN
        // Set takes priority over clear in the same cycle
        ovf_d      = (bus.write & full_q) | (ovf_q & ~bus.ovf_clear);
`else
        ovf_d      = 1'b0;
`endif

        if (!reset_n) begin
            bin_d      = '0;
            gptr_d     = '0;
            rq1_d      = '0;
            rq2_d      = '0;
            level_d    = '0;
            full_d     = 1'b0;
            af_d       = 1'b0;
            ovf_d      = 1'b0;
            in_reset_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        bin_q      <= bin_d;
        gptr_q     <= gptr_d;
        rq1_q      <= rq1_d;
        rq2_q      <= rq2_d;
        level_q    <= level_d;
        full_q     <= full_d;
        af_q       <= af_d;
        ovf_q      <= ovf_d;
        in_reset_q <= in_reset_d;
    end

`ifndef FIFO_WR_OVERFLOW_FLAG_EN
    logic unused_ovf_clear;
    assign unused_ovf_clear = bus.ovf_clear;
`endif

    assign wr_ptr          = gptr_q;
    assign bus.wr_en       = accept;
    assign bus.wr_addr     = bin_q[ADDR_WIDTH-1:0];
    assign bus.full        = full_q;
    assign bus.almost_full = af_q;
    assign bus.wr_level    = level_q;
    assign bus.overflow    = ovf_q;
endmodule
